// File: rtl/weapons_ctrl_fsm.sv
// Missile launch controller: arms on target lock, fires one missile per accepted
// fire request, and locks out permanently once the magazine is empty.
module weapons_ctrl_fsm #(
    parameter int unsigned MAX_MISSILES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       target_locked,
    input  logic       fire_command,
    output logic       launch_missile,
    output logic [3:0] remaining_missiles,
    output logic [1:0] WCU_state
);

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StLocked    = 2'b01,
        StFire      = 2'b10,
        StOutOfAmmo = 2'b11
    } state_t;

    localparam logic [3:0] FullLoad = 4'(MAX_MISSILES);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            count_q <= FullLoad;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (target_locked) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                // Lock loss wins over a simultaneous fire request; the zero guard
                // keeps the counter from ever wrapping.
                if (!target_locked) begin
                    state_d = StIdle;
                end else if (fire_command && (count_q != 4'd0)) begin
                    state_d = StFire;
                    count_d = count_q - 4'd1;
                end
            end
            StFire: begin
                if (count_q == 4'd0) begin
                    state_d = StOutOfAmmo;
                end else if (target_locked) begin
                    state_d = StLocked;
                end else begin
                    state_d = StIdle;
                end
            end
            StOutOfAmmo: begin
                state_d = StOutOfAmmo;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign launch_missile     = (state_q == StFire);
    assign remaining_missiles = count_q;
    assign WCU_state          = state_q;

endmodule

// File: tb/tb_weapons_ctrl_fsm.sv
// Self-checking bench for weapons_ctrl_fsm: directed scenarios followed by random
// lock/fire/reset traffic, all checked against a rule-level behavioural model.
module tb_weapons_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       target_locked = 1'b0;
    logic       fire_command = 1'b0;
    logic       launch_missile;
    logic [3:0] remaining_missiles;
    logic [1:0] WCU_state;

    int total = 0;
    int bad   = 0;

    // Model: inventory count plus three plain facts about the controller.
    int m_ammo;
    bit m_armed;
    bit m_firing;
    bit m_dead;

    weapons_ctrl_fsm #(
        .MAX_MISSILES(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .target_locked     (target_locked),
        .fire_command      (fire_command),
        .launch_missile    (launch_missile),
        .remaining_missiles(remaining_missiles),
        .WCU_state         (WCU_state)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_state();
        if (m_dead) return 2'd3;
        if (m_firing) return 2'd2;
        if (m_armed) return 2'd1;
        return 2'd0;
    endfunction

    function automatic void model_reset();
        m_ammo   = 4;
        m_armed  = 1'b0;
        m_firing = 1'b0;
        m_dead   = 1'b0;
    endfunction

    // One rising edge of the controller, expressed as the operational rules.
    function automatic void model_edge(bit tl, bit fc);
        if (m_dead) begin
            // terminal until reset
        end else if (m_firing) begin
            m_firing = 1'b0;
            if (m_ammo == 0) m_dead = 1'b1;
            else m_armed = tl;
        end else if (m_armed) begin
            if (!tl) begin
                m_armed = 1'b0;
            end else if (fc) begin
                m_armed  = 1'b0;
                m_firing = 1'b1;
                m_ammo   = m_ammo - 1;
            end
        end else if (tl) begin
            m_armed = 1'b1;
        end
    endfunction

    task automatic check(input string tag);
        logic [1:0] es;
        logic [3:0] ea;
        logic       el;
        es = exp_state();
        ea = 4'(m_ammo);
        el = m_firing;
        total++;
        assert (WCU_state === es) else begin
            bad++;
            $error("FAIL %s state: observed %b expected %b", tag, WCU_state, es);
        end
        total++;
        assert (remaining_missiles === ea) else begin
            bad++;
            $error("FAIL %s count: observed %0d expected %0d", tag, remaining_missiles, ea);
        end
        total++;
        assert (launch_missile === el) else begin
            bad++;
            $error("FAIL %s launch: observed %b expected %b", tag, launch_missile, el);
        end
    endtask

    task automatic step(input bit tl, input bit fc, input string tag);
        @(negedge clk);
        target_locked = tl;
        fire_command  = fc;
        @(posedge clk);
        model_edge(tl, fc);
        #1;
        check(tag);
    endtask

    // Called just after a checked edge; reset asserts and releases mid-cycle.
    task automatic async_reset(input string tag);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check(tag);
        #1 rst = 1'b1;
    endtask

    initial begin
        model_reset();
        // 1. reset
        #1 rst = 1'b0;
        #1 check("reset_async");
        repeat (2) @(posedge clk);
        #1 check("reset_held");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "reset_stable");

        // 2. lock and single fire
        step(1'b1, 1'b0, "lock");
        step(1'b1, 1'b1, "fire_accept");
        step(1'b1, 1'b0, "fire_return");
        step(1'b1, 1'b0, "locked_hold");

        // 3. lock-loss priority, fire ignored in idle
        step(1'b0, 1'b1, "lockloss_prio");
        step(1'b0, 1'b1, "idle_fire_ignored");
        step(1'b1, 1'b1, "idle_lock_and_fire");
        step(1'b1, 1'b0, "relocked");

        // 4. exhaustion with fire held
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, "exhaust");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "out_of_ammo_hold");
        step(1'b0, 1'b0, "out_of_ammo_idle_in");

        // 5. async reset in OUT_OF_AMMO and in FIRE
        async_reset("rst_in_ooa");
        step(1'b1, 1'b0, "resume_lock");
        step(1'b1, 1'b1, "resume_fire");
        async_reset("rst_in_fire");
        step(1'b1, 1'b0, "post_rst_lock");
        step(1'b1, 1'b1, "post_rst_fire");

        // 6. lock lost during FIRE
        step(1'b0, 1'b0, "fire_lockloss");
        step(1'b0, 1'b0, "fire_lockloss_idle");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit tl;
            bit fc;
            tl = ($urandom_range(0, 99) < 75);
            fc = ($urandom_range(0, 99) < 50);
            step(tl, fc, "random");
            if ($urandom_range(0, 39) == 0) async_reset("random_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
